// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding, the default width and the counter-width helper.
package serial_sub_pkg;

  localparam int SUB_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Wide enough to count 0..w without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// Combinational 1-bit full subtractor: d = a - b - bi, bo = borrow out.
// Ports: a, b, bi (inputs); d, bo (outputs).
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bi, LSB first, one bit per clock, start/done handshake.
// Ports: clk, rst, start, a, b, bi -> busy, done, d, bo [, ovf with SERIAL_SUB_OVF_EN].
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             dbit;
  logic             br_nxt;
  logic [WIDTH-1:0] res_nxt;

  fullsubtractor u_fs (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .bi (br),
    .d  (dbit),
    .bo (br_nxt)
  );

  assign res_nxt = {dbit, res[WIDTH-1:1]};
  assign busy    = (state == ST_SHIFT);
  assign done    = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      d     <= '0;
      bo    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= res_nxt;
          br   <= br_nxt;
          cnt  <= cnt + 1'b1;
          // Publish on the last bit so results appear in the DONE cycle.
          if (cnt == LAST) begin
            state <= ST_DONE;
            d     <= res_nxt;
            bo    <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // br is the borrow into the MSB here.
            ovf   <= br ^ br_nxt;
`endif
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          if (start) begin
            state <= ST_SHIFT;
            a_sh  <= a;
            b_sh  <= b;
            br    <= bi;
            cnt   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4.
// Define SERIAL_SUB_OVF_EN to also exercise the overflow output.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bi;
  logic       busy;
  logic       done;
  logic [3:0] d;
  logic       bo;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int vectors = 0;
  int errors  = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for done.
  // lat counts cycles from the accepting edge; -1 on timeout.
  task automatic op(input logic [3:0] ia, input logic [3:0] ib,
                    input logic ibi, output int lat,
                    output logic busy_bad, output logic stable_bad);
    logic [3:0] d0;
    logic       bo0;
    start = 1'b1;
    a     = ia;
    b     = ib;
    bi    = ibi;
    tick();
    start = 1'b0;
    a     = 4'($urandom);
    b     = 4'($urandom);
    bi    = 1'($urandom);
    d0    = d;
    bo0   = bo;
    lat   = -1;
    busy_bad   = 1'b0;
    stable_bad = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin
        if (busy) busy_bad = 1'b1;
        lat = i;
        break;
      end
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (d !== d0 || bo !== bo0) stable_bad = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = 4'h0;
    b     = 4'h0;
    bi    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    vectors++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %b want 0", done);
    end
    vectors++;
    if (d !== 4'h0) begin
      errors++;
      $display("FAIL reset_d got %h want 0", d);
    end
    vectors++;
    if (bo !== 1'b0) begin
      errors++;
      $display("FAIL reset_bo got %b want 0", bo);
    end
`ifdef SERIAL_SUB_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got %b want 0", ovf);
    end
`endif
  endtask

  task automatic test_basic();
    logic [3:0] va [5] = '{4'h5, 4'h3, 4'h0, 4'hF, 4'h0};
    logic [3:0] vb [5] = '{4'h3, 4'h5, 4'h0, 4'h0, 4'h1};
    logic       vi [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] ed [5] = '{4'h2, 4'hE, 4'hF, 4'hE, 4'hE};
    logic       eb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int lat;
    logic bb, sb;
    for (int k = 0; k < 5; k++) begin
      op(va[k], vb[k], vi[k], lat, bb, sb);
      vectors++;
      if (lat !== 5) begin
        errors++;
        $display("FAIL basic%0d_latency got %0d want 5", k, lat);
      end
      vectors++;
      if (bb !== 1'b0 || sb !== 1'b0) begin
        errors++;
        $display("FAIL basic%0d_busy_hold got busy_bad=%b stable_bad=%b want 0 0",
                 k, bb, sb);
      end
      vectors++;
      if (d !== ed[k] || bo !== eb[k]) begin
        errors++;
        $display("FAIL basic%0d_result got d=%h bo=%b want d=%h bo=%b",
                 k, d, bo, ed[k], eb[k]);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL basic%0d_idle got done=%b busy=%b want 0 0", k, done, busy);
      end
      vectors++;
      if (d !== ed[k] || bo !== eb[k]) begin
        errors++;
        $display("FAIL basic%0d_hold got d=%h bo=%b want d=%h bo=%b",
                 k, d, bo, ed[k], eb[k]);
      end
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int lat;
    logic bb, sb;
    op(4'h8, 4'h1, 1'b0, lat, bb, sb);
    vectors++;
    if (lat !== 5 || d !== 4'h7 || bo !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_8m1 got lat=%0d d=%h bo=%b ovf=%b want 5 7 0 1",
               lat, d, bo, ovf);
    end
    tick();
    op(4'h7, 4'h1, 1'b0, lat, bb, sb);
    vectors++;
    if (lat !== 5 || d !== 4'h6 || bo !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_7m1 got lat=%0d d=%h bo=%b ovf=%b want 5 6 0 0",
               lat, d, bo, ovf);
    end
    tick();
  endtask
`endif

  task automatic test_ignore_start();
    logic [3:0] d0;
    logic       bo0;
    logic       sb;
    int         lat;
    start = 1'b1;
    a     = 4'h5;
    b     = 4'h3;
    bi    = 1'b0;
    tick();
    start = 1'b0;
    d0    = d;
    bo0   = bo;
    sb    = 1'b0;
    lat   = -1;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (d !== d0 || bo !== bo0) sb = 1'b1;
      start = (i == 2);
      a     = 4'h9;
      b     = 4'h2;
      bi    = 1'b1;
      tick();
    end
    start = 1'b0;
    vectors++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL ignore_latency got %0d want 5", lat);
    end
    vectors++;
    if (sb !== 1'b0) begin
      errors++;
      $display("FAIL ignore_stable got changed=%b want 0", sb);
    end
    vectors++;
    if (d !== 4'h2 || bo !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result got d=%h bo=%b want d=2 bo=0", d, bo);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_queue got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic bb, sb;
    op(4'h6, 4'h2, 1'b0, lat, bb, sb);
    vectors++;
    if (lat !== 5 || d !== 4'h4 || bo !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d d=%h bo=%b want 5 4 0", lat, d, bo);
    end
    // Still in the DONE cycle: the next op starts right here.
    op(4'hF, 4'hF, 1'b0, lat, bb, sb);
    vectors++;
    if (bb !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy got busy_bad=%b want 0", bb);
    end
    vectors++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL b2b_latency got %0d want 5", lat);
    end
    vectors++;
    if (d !== 4'h0 || bo !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got d=%h bo=%b want d=0 bo=0", d, bo);
    end
    tick();
  endtask

  task automatic test_rst_abort();
    int lat;
    logic bb, sb;
    logic seen_done;
    op(4'h5, 4'h3, 1'b0, lat, bb, sb);
    tick();
    start = 1'b1;
    a     = 4'h9;
    b     = 4'h1;
    bi    = 1'b0;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || d !== 4'h0 || bo !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear got busy=%b done=%b d=%h bo=%b want 0 0 0 0",
               busy, done, d, bo);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) seen_done = 1'b1;
      tick();
    end
    vectors++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got activity=%b want 0", seen_done);
    end
    op(4'h9, 4'h4, 1'b0, lat, bb, sb);
    vectors++;
    if (lat !== 5 || d !== 4'h5 || bo !== 1'b0) begin
      errors++;
      $display("FAIL abort_fresh got lat=%0d d=%h bo=%b want 5 5 0", lat, d, bo);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_ignore_start();
    test_back_to_back();
    test_rst_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial multi-bit subtractor with a start/done handshake, computing `a - b - bi` LSB-first, one bit per clock, through a single 1-bit full-subtractor cell. It is the arithmetic counterpart of the team's ripple-carry adder: same operand/borrow conventions, traded area for latency. It sits beside the adder in the ALU datapath experiments and is driven by a simple controller that issues `start` and waits for `done`.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range ≥ 2.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only when the block is idle or in its done cycle.
- `a`  input  WIDTH  minuend; captured on the accepted start.
- `b`  input  WIDTH  subtrahend; captured on the accepted start.
- `bi`  input  1  borrow-in; captured on the accepted start.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  single-cycle pulse when the result is valid.
- `d`  output  WIDTH  difference `(a - b - bi) mod 2^WIDTH`.
- `bo`  output  1  borrow-out; 1 when `a < b + bi` as unsigned values.
- `ovf`  output  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if `start`, latch `a`, `b`, `bi` into the operand/borrow registers, clear the bit counter, and go to SHIFT.
  - SHIFT: process one bit per cycle.
    - Cell: `dbit = a0 ^ b0 ^ br`; `br' = (~a0 & b0) | (~(a0 ^ b0) & br)`.
    - Shift both operand registers right by one.
    - Shift `dbit` into the MSB of the result shift register.
    - Increment the counter.
    - After WIDTH bits, go to DONE.
  - DONE: `done` = 1 for this cycle only.
    - `d` and `bo` are updated as of entry to this cycle.
    - If `start` is high, accept it exactly as in IDLE and go to SHIFT. Otherwise go to IDLE.
- `d`, `bo` and `ovf` hold their last value from DONE until the DONE of the next operation. They do not change while `busy`.
- `start` is ignored while in SHIFT. No queuing.
- Arithmetic is unsigned modulo 2^WIDTH; `bo` is the final borrow register.
- The counter width is `$clog2(WIDTH+1)`. It does not wrap within an operation.

## Timing
- Start accepted at edge T:
  - `busy` is high for cycles T+1 … T+WIDTH.
  - `done` is high in cycle T+WIDTH+1.
  - Latency is WIDTH+1 cycles from the accepting edge to `done`.
- Back-to-back: `start` during the DONE cycle gives `busy` the next cycle. Throughput is one result every WIDTH+1 cycles.
- Reset values: `busy` = 0, `done` = 0, `d` = 0, `bo` = 0, `ovf` = 0. The FSM goes to IDLE.
- `rst` mid-operation aborts on that edge: no `done`, outputs cleared. `rst` has priority over `start`.
- `busy` and `done` are never high in the same cycle.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - The `ovf` port exists.
  - On the final SHIFT bit, `ovf` captures `borrow_into_msb ^ borrow_out_of_msb`, i.e. signed two's-complement overflow.
  - `ovf` has the same hold and reset behaviour as `bo`.
- Not defined:
  - No `ovf` port and no extra register.
  - Otherwise identical cycle behaviour.

## Structure
- Package `serial_sub_pkg`:
  - FSM state enum (IDLE, SHIFT, DONE).
  - Default WIDTH constant.
  - A function computing the counter width.
- Sub-module `fullsubtractor`:
  - Purely combinational 1-bit cell with ports `a`, `b`, `bi`, `d`, `bo`.
  - One instance only; the borrow register feeds back to its `bi`.

## Test plan
- WIDTH=4, a=5, b=3, bi=0, start at T → `busy` high for T+1…T+4, `done` high at T+5, d=0x2, bo=0.
- a=3, b=5, bi=0 → d=0xE, bo=1. Then a=0, b=0, bi=1 → d=0xF, bo=1.
- With `SERIAL_SUB_OVF_EN`:
  - a=0x8, b=0x1, bi=0 → d=0x7, bo=0, ovf=1.
  - a=0x7, b=0x1 → d=0x6, ovf=0.
- `start` pulsed while busy with different operands → ignored; the first result completes unchanged and `d`/`bo` stay stable during `busy`.
- `start` held high through the DONE cycle with new operands a=0xF, b=0xF → `done` pulse, `busy` on the next cycle, second result d=0x0, bo=0 after WIDTH+1 cycles.
- `rst` asserted at T+2 of an operation → no `done`, all outputs 0 the next cycle, FSM idle. A fresh `start` afterwards computes correctly.
